// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and framing strobes.
// A word accepted at edge N shows its first bit on sdo during the cycle after edge N.
// All outputs are decoded from registered state. There is no path from din or din_valid to any output.
module shift_reg_piso_tx #(
   parameter int WIDTH     = 4,
   parameter int GAP       = 0,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sdo,
   output logic             sdo_valid,
   output logic             sof,
   output logic             eof,
   output logic             busy
);

   localparam int BW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt, shreg_shifted;
   logic [BW-1:0]    bcnt, bcnt_nxt;
   logic [3:0]       gcnt, gcnt_nxt;
   logic             last_bit;
   logic             accept;

   // Output decode, taken from registered state only.
   assign last_bit  = (state == S_SHIFT) && (bcnt == LAST_BIT);
   // With no idle gap, a new word can be taken during the last bit, so words stream back to back.
   assign din_ready = (state == S_IDLE) || (last_bit && (GAP == 0));
   assign accept    = din_valid && din_ready;
   assign sdo_valid = (state == S_SHIFT);
   assign sdo       = (state == S_SHIFT) &&
                      ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);
   assign sof       = (state == S_SHIFT) && (bcnt == '0);
   assign eof       = last_bit;
   assign busy      = (state != S_IDLE);

   // Shift one place toward the output end and fill with zeros.
   assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                           : {1'b0, shreg[WIDTH-1:1]};

   // Next-state logic and datapath for the state machine.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      bcnt_nxt  = bcnt;
      gcnt_nxt  = gcnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               shreg_nxt = din;
               bcnt_nxt  = '0;
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_nxt = shreg_shifted;
            bcnt_nxt  = bcnt + 1'b1;
            if (bcnt == LAST_BIT) begin
               bcnt_nxt = '0;
               if (GAP > 0) begin
                  gcnt_nxt  = GAP_LOAD;
                  state_nxt = S_GAP;
               end else if (accept) begin
                  shreg_nxt = din;
                  state_nxt = S_SHIFT;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gcnt == 4'd0) begin
               state_nxt = S_IDLE;
            end else begin
               gcnt_nxt = gcnt - 4'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register. Reset drops any word in flight right away.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Shift register and counters. These clear on reset so no stale bits survive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg <= '0;
         bcnt  <= '0;
         gcnt  <= '0;
      end else begin
         shreg <= shreg_nxt;
         bcnt  <= bcnt_nxt;
         gcnt  <= gcnt_nxt;
      end
   end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed bench for shift_reg_piso_tx. It drives three configurations from one clock:
// the defaults, GAP=2, and WIDTH=8 with LSB first.
module tb_shift_reg_piso_tx;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // DUT A: WIDTH=4, GAP=0, MSB first
   logic [3:0] a_din;
   logic a_vld, a_rdy, a_sdo, a_sv, a_sof, a_eof, a_busy;
   shift_reg_piso_tx #(.WIDTH(4), .GAP(0), .MSB_FIRST(1)) dut_a (
      .clk(clk), .reset(reset), .din(a_din), .din_valid(a_vld), .din_ready(a_rdy),
      .sdo(a_sdo), .sdo_valid(a_sv), .sof(a_sof), .eof(a_eof), .busy(a_busy));

   // DUT B: WIDTH=4, GAP=2, MSB first
   logic [3:0] b_din;
   logic b_vld, b_rdy, b_sdo, b_sv, b_sof, b_eof, b_busy;
   shift_reg_piso_tx #(.WIDTH(4), .GAP(2), .MSB_FIRST(1)) dut_b (
      .clk(clk), .reset(reset), .din(b_din), .din_valid(b_vld), .din_ready(b_rdy),
      .sdo(b_sdo), .sdo_valid(b_sv), .sof(b_sof), .eof(b_eof), .busy(b_busy));

   // DUT C: WIDTH=8, GAP=0, LSB first
   logic [7:0] c_din;
   logic c_vld, c_rdy, c_sdo, c_sv, c_sof, c_eof, c_busy;
   shift_reg_piso_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) dut_c (
      .clk(clk), .reset(reset), .din(c_din), .din_valid(c_vld), .din_ready(c_rdy),
      .sdo(c_sdo), .sdo_valid(c_sv), .sof(c_sof), .eof(c_eof), .busy(c_busy));

   task automatic test_reset();
      @(negedge clk);
      total++;
      if ({a_sdo, a_sv, a_sof, a_eof, a_busy} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outs: got %b want 00000", {a_sdo, a_sv, a_sof, a_eof, a_busy});
      end
      total++;
      if ({b_sv, b_busy, c_sv, c_busy} !== 4'b0) begin
         bad++;
         $display("FAIL reset_outs_bc: got %b want 0000", {b_sv, b_busy, c_sv, c_busy});
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (a_rdy !== 1'b1 || a_sv !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: rdy=%b sv=%b want rdy=1 sv=0", a_rdy, a_sv);
      end
   endtask

   task automatic test_single();
      logic [3:0] exp_w;
      logic [3:0] shadow;
      exp_w  = 4'b1011;
      shadow = 4'h0;
      a_din = exp_w;
      a_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            a_vld = 1'b0;
            a_din = 4'h0;
         end
         total++;
         if (a_sv !== 1'b1 || a_sdo !== exp_w[3-i]) begin
            bad++;
            $display("FAIL single_bit%0d: sv=%b sdo=%b want sv=1 sdo=%b", i, a_sv, a_sdo, exp_w[3-i]);
         end
         total++;
         if (a_sof !== (i == 0) || a_eof !== (i == 3)) begin
            bad++;
            $display("FAIL single_frame%0d: sof=%b eof=%b want sof=%b eof=%b",
                     i, a_sof, a_eof, (i == 0), (i == 3));
         end
         shadow = {shadow[2:0], a_sdo};
      end
      total++;
      if (shadow !== 4'b1011) begin
         bad++;
         $display("FAIL single_shadow: got %b want 1011", shadow);
      end
      @(negedge clk);
      total++;
      if (a_sv !== 1'b0 || a_busy !== 1'b0 || a_rdy !== 1'b1) begin
         bad++;
         $display("FAIL single_idle: sv=%b busy=%b rdy=%b want 0 0 1", a_sv, a_busy, a_rdy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_s;
      exp_s = 8'b1010_0101;
      a_din = 4'hA;
      a_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if (a_sv !== 1'b1 || a_sdo !== exp_s[7-i]) begin
            bad++;
            $display("FAIL b2b_bit%0d: sv=%b sdo=%b want sv=1 sdo=%b", i, a_sv, a_sdo, exp_s[7-i]);
         end
         total++;
         if (a_rdy !== (i == 3 || i == 7)) begin
            bad++;
            $display("FAIL b2b_rdy%0d: got %b want %b", i, a_rdy, (i == 3 || i == 7));
         end
         if (i == 0) a_din = 4'h5;
         if (i == 4) begin
            a_vld = 1'b0;
            a_din = 4'h0;
         end
      end
      @(negedge clk);
      total++;
      if (a_sv !== 1'b0 || a_busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end: sv=%b busy=%b want 0 0", a_sv, a_busy);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_s;
      exp_s = 8'b0011_0110;
      @(negedge clk);
      total++;
      if (a_rdy !== 1'b1) begin
         bad++;
         $display("FAIL bp_start_rdy: got %b want 1", a_rdy);
      end
      a_din = 4'h3;
      a_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if (a_sv !== 1'b1 || a_sdo !== exp_s[7-i]) begin
            bad++;
            $display("FAIL bp_bit%0d: sv=%b sdo=%b want sv=1 sdo=%b", i, a_sv, a_sdo, exp_s[7-i]);
         end
         total++;
         if (a_rdy !== (i == 3 || i == 7)) begin
            bad++;
            $display("FAIL bp_rdy%0d: got %b want %b", i, a_rdy, (i == 3 || i == 7));
         end
         case (i)
            0: a_din = 4'hF;
            1: a_din = 4'hE;
            2: a_din = 4'h9;
            3: a_din = 4'h6;
            4: begin a_vld = 1'b0; a_din = 4'hA; end
            default: ;
         endcase
      end
      @(negedge clk);
      total++;
      if (a_sv !== 1'b0 || a_rdy !== 1'b1) begin
         bad++;
         $display("FAIL bp_end: sv=%b rdy=%b want 0 1", a_sv, a_rdy);
      end
   endtask

   task automatic test_reset_mid();
      a_din = 4'b1011;
      a_vld = 1'b1;
      @(negedge clk);
      a_vld = 1'b0;
      total++;
      if (a_sdo !== 1'b1 || a_sof !== 1'b1) begin
         bad++;
         $display("FAIL rmid_bit0: sdo=%b sof=%b want 1 1", a_sdo, a_sof);
      end
      @(negedge clk);
      total++;
      if (a_sv !== 1'b1 || a_sdo !== 1'b0) begin
         bad++;
         $display("FAIL rmid_bit1: sv=%b sdo=%b want 1 0", a_sv, a_sdo);
      end
      #2 reset = 1'b1;
      a_din = 4'hF;
      a_vld = 1'b1;
      #1;
      total++;
      if ({a_sdo, a_sv, a_sof, a_eof, a_busy} !== 5'b0) begin
         bad++;
         $display("FAIL rmid_async: got %b want 00000", {a_sdo, a_sv, a_sof, a_eof, a_busy});
      end
      @(negedge clk);
      total++;
      if (a_sv !== 1'b0 || a_busy !== 1'b0) begin
         bad++;
         $display("FAIL rmid_hold: sv=%b busy=%b want 0 0", a_sv, a_busy);
      end
      reset = 1'b0;
      a_vld = 1'b0;
      a_din = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (a_sv !== 1'b0 || a_sdo !== 1'b0 || a_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rmid_after%0d: sv=%b sdo=%b rdy=%b want 0 0 1", i, a_sv, a_sdo, a_rdy);
         end
      end
   endtask

   task automatic test_gap();
      bit e_sv   [14];
      bit e_sdo  [14];
      bit e_rdy  [14];
      bit e_busy [14];
      e_sv   = '{1,1,1,1,0,0,0,1,1,1,1,0,0,0};
      e_sdo  = '{1,0,0,1,0,0,0,0,1,1,0,0,0,0};
      e_rdy  = '{0,0,0,0,0,0,1,0,0,0,0,0,0,1};
      e_busy = '{1,1,1,1,1,1,0,1,1,1,1,1,1,0};
      @(negedge clk);
      b_din = 4'h9;
      b_vld = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         total++;
         if (b_sv !== e_sv[k] || b_sdo !== e_sdo[k]) begin
            bad++;
            $display("FAIL gap_data%0d: sv=%b sdo=%b want sv=%b sdo=%b", k, b_sv, b_sdo, e_sv[k], e_sdo[k]);
         end
         total++;
         if (b_rdy !== e_rdy[k] || b_busy !== e_busy[k]) begin
            bad++;
            $display("FAIL gap_ctl%0d: rdy=%b busy=%b want rdy=%b busy=%b", k, b_rdy, b_busy, e_rdy[k], e_busy[k]);
         end
         if (k == 0) b_din = 4'h6;
         if (k == 7) begin
            b_vld = 1'b0;
            b_din = 4'h0;
         end
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] exp_w;
      logic [7:0] got_w;
      exp_w = 8'hC3;
      got_w = 8'h00;
      @(negedge clk);
      c_din = exp_w;
      c_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            c_vld = 1'b0;
            c_din = 8'h00;
         end
         total++;
         if (c_sv !== 1'b1 || c_sdo !== exp_w[i]) begin
            bad++;
            $display("FAIL lsb_bit%0d: sv=%b sdo=%b want sv=1 sdo=%b", i, c_sv, c_sdo, exp_w[i]);
         end
         total++;
         if (c_sof !== (i == 0) || c_eof !== (i == 7)) begin
            bad++;
            $display("FAIL lsb_frame%0d: sof=%b eof=%b want sof=%b eof=%b",
                     i, c_sof, c_eof, (i == 0), (i == 7));
         end
         got_w[i] = c_sdo;
      end
      total++;
      if (got_w !== 8'hC3) begin
         bad++;
         $display("FAIL lsb_word: got %h want c3", got_w);
      end
      @(negedge clk);
      total++;
      if (c_sv !== 1'b0 || c_rdy !== 1'b1) begin
         bad++;
         $display("FAIL lsb_end: sv=%b rdy=%b want 0 1", c_sv, c_rdy);
      end
   endtask

   initial begin
      reset = 1'b1;
      a_din = '0; a_vld = 1'b0;
      b_din = '0; b_vld = 1'b0;
      c_din = '0; c_vld = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_gap();
      test_lsb_first();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
